// File: rtl/aes_pkg.sv
// Shared AES-128 constants and the key-schedule controller state encoding.
package aes_pkg;

   localparam int AES128_LAST_ROUND = 10;
   localparam int AES128_KEY_W      = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      PRESENT = 2'd3
   } ks_state_t;

endpackage

// File: rtl/aes128_key_sched_ctrl_if.sv
// Key-input and round-key handshakes of the AES-128 key-schedule controller.
interface aes128_key_sched_ctrl_if
   import aes_pkg::*;
#(
   parameter int KEY_W = AES128_KEY_W
);

   logic [KEY_W-1:0] key_in;
   logic             key_in_valid;
   logic             key_in_ready;

   logic [KEY_W-1:0] rk_out;
   logic [3:0]       rk_round;
   logic             rk_valid;
   logic             rk_ready;
   logic             rk_last;

   // master: the controller (accepts cipher keys, sources round keys)
   modport master (
      input  key_in, key_in_valid, rk_ready,
      output key_in_ready, rk_out, rk_round, rk_valid, rk_last
   );

   // slave: the surrounding logic (sources cipher keys, consumes round keys)
   modport slave (
      output key_in, key_in_valid, rk_ready,
      input  key_in_ready, rk_out, rk_round, rk_valid, rk_last
   );

endinterface

// File: rtl/aes128_key_sched_ctrl.sv
// Sequences the external AES-128 key generator through rounds 0..LAST_ROUND and
// hands each captured round key to the encryption datapath over valid/ready.
module aes128_key_sched_ctrl
   import aes_pkg::*;
#(
   parameter int KEY_W      = AES128_KEY_W,
   parameter int LAST_ROUND = AES128_LAST_ROUND
) (
   input  logic                    clk,
   input  logic                    rst,
   aes128_key_sched_ctrl_if.master ks,
   input  logic                    abort,
   output logic                    kg_en,
   output logic [3:0]              kg_round,
   output logic [KEY_W-1:0]        kg_key,
   input  logic [KEY_W-1:0]        kg_current_key,
   input  logic                    kg_key_valid,
   output logic                    busy,
   output logic                    done
);

   localparam logic [3:0] LAST_R = 4'(LAST_ROUND);

   ks_state_t        state;
   logic [3:0]       r;
   logic [KEY_W-1:0] key_reg;

   assign kg_round        = r;
   assign kg_key          = key_reg;
   assign ks.key_in_ready = (state == IDLE);
   assign busy            = (state != IDLE);
   assign ks.rk_last      = ks.rk_valid && (ks.rk_round == LAST_R);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state       <= IDLE;
         r           <= '0;
         key_reg     <= '0;
         kg_en       <= 1'b0;
         done        <= 1'b0;
         ks.rk_out   <= '0;
         ks.rk_round <= '0;
         ks.rk_valid <= 1'b0;
      end else begin
         kg_en <= 1'b0;
         done  <= 1'b0;
         if (abort && (state != IDLE)) begin
            state       <= IDLE;
            ks.rk_valid <= 1'b0;
         end else begin
            // kg_en is raised on every entry into ISSUE so it is high for exactly that cycle
            case (state)
               IDLE: begin
                  if (ks.key_in_valid) begin
                     key_reg <= ks.key_in;
                     r       <= '0;
                     kg_en   <= 1'b1;
                     state   <= ISSUE;
                  end
               end
               ISSUE: begin
                  state <= WAIT;
               end
               WAIT: begin
                  if (kg_key_valid) begin
                     ks.rk_out   <= kg_current_key;
                     ks.rk_round <= r;
                     ks.rk_valid <= 1'b1;
                     state       <= PRESENT;
                  end
               end
               PRESENT: begin
                  if (ks.rk_ready) begin
                     ks.rk_valid <= 1'b0;
                     if (r == LAST_R) begin
                        done  <= 1'b1;
                        state <= IDLE;
                     end else begin
                        r     <= r + 4'd1;
                        kg_en <= 1'b1;
                        state <= ISSUE;
                     end
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
// Bench for aes128_key_sched_ctrl: behavioural AES-128 key generator plus a
// round-key scoreboard, driven by directed steps.
module tb_aes128_key_sched_ctrl;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   localparam logic [127:0] KF   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KF1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] KF10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;

   typedef struct packed {
      logic [127:0] key;
      logic [3:0]   rnd;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         abort;
   logic         kg_en;
   logic [3:0]   kg_round;
   logic [127:0] kg_key;
   logic [127:0] kg_current_key;
   logic         kg_key_valid;
   logic         busy;
   logic         done;

   logic [127:0] gen_prev, gen_cur;
   logic         gen_kv;
   logic         force_kv;
   logic [127:0] junk_key;

   exp_t         exp_q[$];
   logic [127:0] sched [0:10];
   int           checks = 0;
   int           errors = 0;

   aes128_key_sched_ctrl_if #(.KEY_W(128)) ksif ();

   aes128_key_sched_ctrl #(.KEY_W(128), .LAST_ROUND(10)) dut (
      .clk            (clk),
      .rst            (rst),
      .ks             (ksif),
      .abort          (abort),
      .kg_en          (kg_en),
      .kg_round       (kg_round),
      .kg_key         (kg_key),
      .kg_current_key (kg_current_key),
      .kg_key_valid   (kg_key_valid),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] sb(input logic [7:0] b);
      return SBOX[(255 - int'(b)) * 8 +: 8];
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] rnd);
      case (rnd)
         4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
         4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
         4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
         4'd10: return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] expand(input logic [127:0] p, input logic [3:0] rnd);
      logic [31:0] w0, w1, w2, w3, t;
      {w0, w1, w2, w3} = p;
      t = {sb(w3[23:16]), sb(w3[15:8]), sb(w3[7:0]), sb(w3[31:24])};
      t[31:24] = t[31:24] ^ rcon(rnd);
      w0 = w0 ^ t;
      w1 = w1 ^ w0;
      w2 = w2 ^ w1;
      w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Key generator model: one-cycle latency, chains from its previous output
   always @(posedge clk) begin
      if (!rst) begin
         gen_prev <= '0;
         gen_cur  <= '0;
         gen_kv   <= 1'b0;
      end else begin
         gen_kv <= kg_en;
         if (kg_en) begin
            gen_cur  <= (kg_round == 4'd0) ? kg_key : expand(gen_prev, kg_round);
            gen_prev <= (kg_round == 4'd0) ? kg_key : expand(gen_prev, kg_round);
         end
      end
   end

   assign kg_current_key = force_kv ? junk_key : gen_cur;
   assign kg_key_valid   = gen_kv | force_kv;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic push_schedule(input logic [127:0] k);
      sched[0] = k;
      for (int i = 1; i <= 10; i++) sched[i] = expand(sched[i-1], 4'(i));
      for (int i = 0; i <= 10; i++) exp_q.push_back('{key: sched[i], rnd: 4'(i)});
   endtask

   // Scores the handshake that the coming edge completes, then advances one cycle
   task automatic tick();
      exp_t e;
      if (rst && ksif.rk_valid && ksif.rk_ready) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL sb_extra: observed round %0d with empty queue, expected no round key", ksif.rk_round);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_rk_out", ksif.rk_out, e.key);
            chk("sb_rk_round", 128'(ksif.rk_round), 128'(e.rnd));
            chk("sb_rk_last", 128'(ksif.rk_last), 128'(e.rnd == 4'd10));
         end
      end
      @(negedge clk);
   endtask

   task automatic send_key(input logic [127:0] k);
      int n = 0;
      while (ksif.key_in_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("send_ready", 128'(ksif.key_in_ready), 128'(1'b1));
      ksif.key_in       = k;
      ksif.key_in_valid = 1'b1;
      push_schedule(k);
      tick();
      ksif.key_in_valid = 1'b0;
   endtask

   task automatic run_to_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk({tag, "_done"}, 128'(done), 128'(1'b1));
      chk({tag, "_sb_empty"}, 128'(exp_q.size()), 128'(0));
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_kg_en"}, 128'(kg_en), 128'(0));
      chk({tag, "_kg_round"}, 128'(kg_round), 128'(0));
      chk({tag, "_kg_key"}, kg_key, 128'(0));
      chk({tag, "_rk_out"}, ksif.rk_out, 128'(0));
      chk({tag, "_rk_round"}, 128'(ksif.rk_round), 128'(0));
      chk({tag, "_rk_valid"}, 128'(ksif.rk_valid), 128'(0));
      chk({tag, "_rk_last"}, 128'(ksif.rk_last), 128'(0));
      chk({tag, "_busy"}, 128'(busy), 128'(0));
      chk({tag, "_done"}, 128'(done), 128'(0));
      chk({tag, "_key_in_ready"}, 128'(ksif.key_in_ready), 128'(1));
   endtask

   initial begin
      rst               = 1'b0;
      abort             = 1'b0;
      force_kv          = 1'b0;
      junk_key          = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      ksif.key_in       = '0;
      ksif.key_in_valid = 1'b0;
      ksif.rk_ready     = 1'b1;
      repeat (3) tick();
      check_reset_vals("reset");
      rst = 1'b1;
      tick();

      // FIPS-197 vector, rk_ready tied high
      send_key(KF);
      for (int n = 1; n <= 34; n++) begin
         case (n)
            1: begin
               chk("fips_c1_kg_en", 128'(kg_en), 128'(1));
               chk("fips_c1_kg_round", 128'(kg_round), 128'(0));
               chk("fips_c1_kg_key", kg_key, KF);
               chk("fips_c1_key_in_ready", 128'(ksif.key_in_ready), 128'(0));
            end
            2: begin
               chk("fips_c2_kg_en", 128'(kg_en), 128'(0));
               chk("fips_c2_rk_valid", 128'(ksif.rk_valid), 128'(0));
            end
            3: begin
               chk("fips_c3_rk_valid", 128'(ksif.rk_valid), 128'(1));
               chk("fips_c3_rk_out", ksif.rk_out, KF);
            end
            4: begin
               chk("fips_c4_kg_en", 128'(kg_en), 128'(1));
               chk("fips_c4_kg_round", 128'(kg_round), 128'(1));
            end
            6: begin
               chk("fips_c6_rk_out", ksif.rk_out, KF1);
               chk("fips_c6_rk_round", 128'(ksif.rk_round), 128'(1));
            end
            33: begin
               chk("fips_c33_rk_out", ksif.rk_out, KF10);
               chk("fips_c33_rk_last", 128'(ksif.rk_last), 128'(1));
               chk("fips_c33_done", 128'(done), 128'(0));
            end
            34: begin
               chk("fips_c34_done", 128'(done), 128'(1));
               chk("fips_c34_key_in_ready", 128'(ksif.key_in_ready), 128'(1));
               chk("fips_c34_busy", 128'(busy), 128'(0));
               chk("fips_sb_empty", 128'(exp_q.size()), 128'(0));
            end
            default: ;
         endcase
         tick();
      end
      chk("fips_c35_done", 128'(done), 128'(0));

      // Backpressure: five stall cycles on round 4
      send_key(KF);
      for (int n = 1; n <= 39; n++) begin
         if (n == 15) begin
            chk("bp_c15_rk_round", 128'(ksif.rk_round), 128'(4));
            ksif.rk_ready = 1'b0;
         end
         if (n >= 16 && n <= 20) begin
            chk("bp_hold_rk_out", ksif.rk_out, sched[4]);
            chk("bp_hold_rk_round", 128'(ksif.rk_round), 128'(4));
            chk("bp_hold_rk_valid", 128'(ksif.rk_valid), 128'(1));
            chk("bp_hold_kg_en", 128'(kg_en), 128'(0));
         end
         if (n == 20) ksif.rk_ready = 1'b1;
         if (n == 38) chk("bp_c38_done", 128'(done), 128'(0));
         if (n == 39) begin
            chk("bp_c39_done", 128'(done), 128'(1));
            chk("bp_sb_empty", 128'(exp_q.size()), 128'(0));
         end
         tick();
      end

      // Spurious generator valid while presenting round 2
      send_key(K2);
      for (int n = 1; n <= 12; n++) begin
         if (n == 9) begin
            chk("spur_c9_rk_round", 128'(ksif.rk_round), 128'(2));
            ksif.rk_ready = 1'b0;
            force_kv      = 1'b1;
         end
         if (n == 10 || n == 11) begin
            chk("spur_rk_out", ksif.rk_out, sched[2]);
            chk("spur_rk_round", 128'(ksif.rk_round), 128'(2));
         end
         if (n == 11) begin
            force_kv      = 1'b0;
            ksif.rk_ready = 1'b1;
         end
         tick();
      end
      run_to_done("spur");

      // Abort during WAIT of round 3
      send_key(KF);
      for (int n = 1; n <= 10; n++) tick();
      chk("abort_c11_busy", 128'(busy), 128'(1));
      chk("abort_c11_kg_round", 128'(kg_round), 128'(3));
      chk("abort_c11_rk_valid", 128'(ksif.rk_valid), 128'(0));
      chk("abort_c11_pending", 128'(exp_q.size()), 128'(8));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", 128'(busy), 128'(0));
      chk("abort_rk_valid", 128'(ksif.rk_valid), 128'(0));
      chk("abort_kg_en", 128'(kg_en), 128'(0));
      chk("abort_key_in_ready", 128'(ksif.key_in_ready), 128'(1));
      exp_q.delete();
      for (int n = 0; n < 3; n++) begin
         chk("abort_no_done", 128'(done), 128'(0));
         tick();
      end
      send_key(K2);
      run_to_done("abort_next");

      // Second key held valid while busy; accepted in the done cycle
      tick();
      ksif.key_in       = KF;
      ksif.key_in_valid = 1'b1;
      push_schedule(KF);
      tick();
      ksif.key_in = K2;
      for (int n = 1; n <= 34; n++) begin
         if (n == 1 || n == 12 || n == 30) begin
            chk("busy_key_in_ready", 128'(ksif.key_in_ready), 128'(0));
            chk("busy_kg_key", kg_key, KF);
         end
         if (n == 34) begin
            chk("busy_c34_done", 128'(done), 128'(1));
            chk("busy_c34_key_in_ready", 128'(ksif.key_in_ready), 128'(1));
            chk("busy_first_sb_empty", 128'(exp_q.size()), 128'(0));
            push_schedule(K2);
         end
         tick();
      end
      ksif.key_in_valid = 1'b0;
      chk("busy_k2_kg_key", kg_key, K2);
      chk("busy_k2_kg_en", 128'(kg_en), 128'(1));
      run_to_done("busy_k2");

      // Reset while presenting round 7
      send_key(KF);
      for (int n = 1; n <= 23; n++) tick();
      chk("mrst_c24_rk_round", 128'(ksif.rk_round), 128'(7));
      chk("mrst_c24_rk_valid", 128'(ksif.rk_valid), 128'(1));
      rst = 1'b0;
      tick();
      check_reset_vals("mrst");
      exp_q.delete();
      rst = 1'b1;
      tick();
      send_key(K2);
      run_to_done("mrst_next");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no end of stimulus, expected completion before time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
